// File: rtl/inta_ack_sequencer_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer: FSM encoding,
// IR id geometry and the one-hot helper used for ISR/IRR updates.
package inta_ack_sequencer_pkg;

    localparam int ID_W             = 3;
    localparam int NUM_IR           = 8;
    localparam int SPURIOUS_DEFAULT = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PEND  = 3'd1,
        ST_ACK1  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_ACK2  = 3'd4
    } state_t;

    // Bit i of the result (ascending range, bit 0 leftmost) is IR level i.
    function automatic logic [0:NUM_IR-1] ir_onehot(input logic [0:ID_W-1] id);
        logic [0:NUM_IR-1] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/inta_edge_sync.sv
// Synchronizes the asynchronous INTA# strobe and produces one-cycle fall/rise
// event pulses from the synchronized level.
module inta_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   level;

    // Reset to the idle (high) level so release of reset never looks like a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
            edge_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], inta_n};
            edge_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign fall  = edge_reg & ~level;
    assign rise  = ~edge_reg & level;

endmodule

// File: rtl/inta_ack_sequencer.sv
// 8086-mode interrupt-acknowledge responder: raises INT, latches the winning IR
// on INTA#1, drives the vector on INTA#2, and maintains ISR with EOI/AEOI.
module inta_ack_sequencer
    import inta_ack_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SPURIOUS_ID = SPURIOUS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_interrupt_flag,
    input  logic [0:2]  current_highest_priority_id,
    input  logic        inta_n,
    input  logic [0:4]  vector_base,
    input  logic        auto_eoi,
    input  logic        eoi_valid,
    input  logic        eoi_specific,
    input  logic [0:2]  eoi_level,
    input  logic [0:2]  eoi_nonspecific_id,
    output logic        int_out,
    output logic [0:7]  isr,
    output logic [0:7]  irr_clear,
    output logic [0:7]  data_out,
    output logic        data_oe
);

    localparam logic [0:ID_W-1] SPUR_ID = ID_W'(SPURIOUS_ID);

    logic inta_fall;
    logic inta_rise;

    state_t              state_reg,     state_next;
    logic                int_out_reg,   int_out_next;
    logic [0:NUM_IR-1]   isr_reg,       isr_next;
    logic [0:NUM_IR-1]   irr_clear_reg, irr_clear_next;
    logic [0:7]          data_out_reg,  data_out_next;
    logic                data_oe_reg,   data_oe_next;
    logic [0:ID_W-1]     id_reg,        id_next;
    logic                spurious_reg,  spurious_next;
    logic [0:NUM_IR-1]   isr_set;
    logic [0:NUM_IR-1]   isr_clr;

    inta_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .inta_n (inta_n),
        .fall   (inta_fall),
        .rise   (inta_rise)
    );

    always_comb begin
        state_next     = state_reg;
        int_out_next   = int_out_reg;
        id_next        = id_reg;
        spurious_next  = spurious_reg;
        data_out_next  = data_out_reg;
        data_oe_next   = data_oe_reg;
        irr_clear_next = '0;
        isr_set        = '0;
        isr_clr        = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start_interrupt_flag) begin
                    state_next   = ST_PEND;
                    int_out_next = 1'b1;
                end
            end
            ST_PEND: begin
                // The fall event takes precedence: a flag dropping in the same
                // cycle yields a spurious acknowledge rather than a silent abort.
                if (inta_fall) begin
                    state_next   = ST_ACK1;
                    int_out_next = 1'b0;
                    if (start_interrupt_flag) begin
                        id_next        = current_highest_priority_id;
                        spurious_next  = 1'b0;
                        isr_set        = ir_onehot(current_highest_priority_id);
                        irr_clear_next = ir_onehot(current_highest_priority_id);
                    end else begin
                        id_next       = SPUR_ID;
                        spurious_next = 1'b1;
                    end
                end else if (!start_interrupt_flag) begin
                    state_next   = ST_IDLE;
                    int_out_next = 1'b0;
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_next = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    state_next    = ST_ACK2;
                    data_out_next = {vector_base, id_reg};
                    data_oe_next  = 1'b1;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_next    = ST_IDLE;
                    data_out_next = '0;
                    data_oe_next  = 1'b0;
                    if (auto_eoi && !spurious_reg) begin
                        isr_clr = ir_onehot(id_reg);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (eoi_valid) begin
            isr_clr = isr_clr | ir_onehot(eoi_specific ? eoi_level : eoi_nonspecific_id);
        end

        // Set is applied after clear so a same-bit collision keeps the bit in service.
        isr_next = (isr_reg & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            int_out_reg   <= 1'b0;
            isr_reg       <= '0;
            irr_clear_reg <= '0;
            data_out_reg  <= '0;
            data_oe_reg   <= 1'b0;
            id_reg        <= '0;
            spurious_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            int_out_reg   <= int_out_next;
            isr_reg       <= isr_next;
            irr_clear_reg <= irr_clear_next;
            data_out_reg  <= data_out_next;
            data_oe_reg   <= data_oe_next;
            id_reg        <= id_next;
            spurious_reg  <= spurious_next;
        end
    end

    assign int_out   = int_out_reg;
    assign isr       = isr_reg;
    assign irr_clear = irr_clear_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;

endmodule

// File: tb/tb_inta_ack_sequencer.sv
// Directed bench for inta_ack_sequencer: normal, AEOI, spurious, EOI, reset and
// resolver-change scenarios with hand-computed expected values.
module tb_inta_ack_sequencer;

    logic        clk;
    logic        reset;
    logic        start_interrupt_flag;
    logic [0:2]  current_highest_priority_id;
    logic        inta_n;
    logic [0:4]  vector_base;
    logic        auto_eoi;
    logic        eoi_valid;
    logic        eoi_specific;
    logic [0:2]  eoi_level;
    logic [0:2]  eoi_nonspecific_id;
    logic        int_out;
    logic [0:7]  isr;
    logic [0:7]  irr_clear;
    logic [0:7]  data_out;
    logic        data_oe;

    int total;
    int bad;

    inta_ack_sequencer dut (
        .clk                         (clk),
        .reset                       (reset),
        .start_interrupt_flag        (start_interrupt_flag),
        .current_highest_priority_id (current_highest_priority_id),
        .inta_n                      (inta_n),
        .vector_base                 (vector_base),
        .auto_eoi                    (auto_eoi),
        .eoi_valid                   (eoi_valid),
        .eoi_specific                (eoi_specific),
        .eoi_level                   (eoi_level),
        .eoi_nonspecific_id          (eoi_nonspecific_id),
        .int_out                     (int_out),
        .isr                         (isr),
        .irr_clear                   (irr_clear),
        .data_out                    (data_out),
        .data_oe                     (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
        $display("check %-16s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive INTA# and wait until the synchronized event has been registered.
    task automatic inta_low();
        inta_n = 1'b0;
        ticks(3);
    endtask

    task automatic inta_high();
        inta_n = 1'b1;
        ticks(3);
    endtask

    task automatic full_ack(input logic [0:2] id);
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = id;
        ticks(1);
        inta_low();
        start_interrupt_flag = 1'b0;
        inta_high();
        inta_low();
        inta_high();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start_interrupt_flag        = 1'b0;
        current_highest_priority_id = 3'd0;
        inta_n             = 1'b1;
        vector_base        = 5'h08;
        auto_eoi           = 1'b0;
        eoi_valid          = 1'b0;
        eoi_specific       = 1'b0;
        eoi_level          = 3'd0;
        eoi_nonspecific_id = 3'd0;
        ticks(3);
        chk("rst_int",  8'(int_out), 8'h00);
        chk("rst_isr",  isr,         8'h00);
        chk("rst_irr",  irr_clear,   8'h00);
        chk("rst_data", data_out,    8'h00);
        chk("rst_oe",   8'(data_oe), 8'h00);
        reset = 1'b0;
        ticks(2);

        // 1. Normal two-pulse acknowledge of IR3 with base 0x08.
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd3;
        chk("t1_int_pre", 8'(int_out), 8'h00);
        ticks(1);
        chk("t1_int_1clk", 8'(int_out), 8'h01);
        inta_n = 1'b0;
        ticks(2);
        chk("t1_isr_early", isr, 8'h00);
        ticks(1);
        chk("t1_isr",     isr,         8'h10);
        chk("t1_irr",     irr_clear,   8'h10);
        chk("t1_int_low", 8'(int_out), 8'h00);
        start_interrupt_flag = 1'b0;
        ticks(1);
        chk("t1_irr_pulse", irr_clear, 8'h00);
        inta_high();
        chk("t1_oe_ack1", 8'(data_oe), 8'h00);
        inta_low();
        chk("t1_data", data_out,    8'h43);
        chk("t1_oe",   8'(data_oe), 8'h01);
        inta_high();
        chk("t1_oe_off",   8'(data_oe), 8'h00);
        chk("t1_data_off", data_out,    8'h00);
        chk("t1_isr_kept", isr,         8'h10);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
        ticks(1);
        eoi_valid = 1'b0;
        chk("t1_eoi", isr, 8'h00);

        // 2. AEOI clears the in-service bit on the INTA#2 rise.
        auto_eoi = 1'b1;
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd3;
        ticks(1);
        inta_low();
        chk("t2_isr_set", isr, 8'h10);
        start_interrupt_flag = 1'b0;
        inta_high();
        inta_low();
        chk("t2_data", data_out, 8'h43);
        chk("t2_isr_hold", isr, 8'h10);
        inta_high();
        chk("t2_aeoi", isr, 8'h00);
        chk("t2_oe",   8'(data_oe), 8'h00);
        auto_eoi = 1'b0;

        // 3a. Flag drops one clock before the fall event: back to IDLE, no vector.
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd5;
        ticks(1);
        chk("t3a_int", 8'(int_out), 8'h01);
        inta_n = 1'b0;
        ticks(1);
        start_interrupt_flag = 1'b0;
        ticks(1);
        chk("t3a_int_drop", 8'(int_out), 8'h00);
        ticks(1);
        chk("t3a_isr", isr,       8'h00);
        chk("t3a_irr", irr_clear, 8'h00);
        inta_high();
        inta_low();
        chk("t3a_no_oe", 8'(data_oe), 8'h00);
        inta_high();

        // 3b. Flag drop coincident with the fall event: spurious id 7.
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd5;
        ticks(1);
        inta_n = 1'b0;
        ticks(2);
        start_interrupt_flag = 1'b0;
        ticks(1);
        chk("t3b_isr", isr,       8'h00);
        chk("t3b_irr", irr_clear, 8'h00);
        inta_high();
        inta_low();
        chk("t3b_data", data_out,    8'h47);
        chk("t3b_oe",   8'(data_oe), 8'h01);
        inta_high();
        chk("t3b_oe_off", 8'(data_oe), 8'h00);

        // 4. EOI handling: set IR1 and IR3, non-specific then specific.
        full_ack(3'd1);
        full_ack(3'd3);
        chk("t4_isr_13", isr, 8'h50);
        eoi_valid = 1'b1; eoi_specific = 1'b0; eoi_nonspecific_id = 3'd1;
        ticks(1);
        eoi_valid = 1'b0;
        chk("t4_nonspec", isr, 8'h10);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
        ticks(1);
        eoi_valid = 1'b0;
        chk("t4_spec", isr, 8'h00);
        // Specific EOI of 3 in the same cycle as a new ack of 3: set wins.
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd3;
        ticks(1);
        inta_n = 1'b0;
        ticks(2);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
        ticks(1);
        eoi_valid = 1'b0;
        start_interrupt_flag = 1'b0;
        chk("t4_set_wins", isr, 8'h10);
        inta_high();
        inta_low();
        inta_high();
        // Non-specific EOI of 3 in the same cycle as ack of 6: both apply.
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd6;
        ticks(1);
        inta_n = 1'b0;
        ticks(2);
        eoi_valid = 1'b1; eoi_specific = 1'b0; eoi_nonspecific_id = 3'd3;
        ticks(1);
        eoi_valid = 1'b0;
        start_interrupt_flag = 1'b0;
        chk("t4_both", isr, 8'h02);
        inta_high();
        inta_low();
        inta_high();

        // 5. Reset asserted during ACK2 clears outputs asynchronously.
        start_interrupt_flag        = 1'b1;
        current_highest_priority_id = 3'd2;
        ticks(1);
        inta_low();
        start_interrupt_flag = 1'b0;
        inta_high();
        inta_low();
        chk("t5_oe_pre", 8'(data_oe), 8'h01);
        #2;
        reset  = 1'b1;
        inta_n = 1'b1;
        #1;
        chk("t5_oe",   8'(data_oe), 8'h00);
        chk("t5_int",  8'(int_out), 8'h00);
        chk("t5_isr",  isr,         8'h00);
        chk("t5_data", data_out,    8'h00);
        ticks(2);
        reset = 1'b0;
        ticks(4);
        start_interrupt_flag = 1'b1;
        ticks(1);
        chk("t5_idle_int", 8'(int_out), 8'h01);

        // 6. Resolver id changes 2 -> 6 after INTA#1: vector keeps id 2.
        current_highest_priority_id = 3'd2;
        inta_low();
        chk("t6_isr", isr,       8'h20);
        chk("t6_irr", irr_clear, 8'h20);
        current_highest_priority_id = 3'd6;
        inta_high();
        inta_low();
        chk("t6_data", data_out, 8'h42);
        start_interrupt_flag = 1'b0;
        inta_high();
        chk("t6_oe_off", 8'(data_oe), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
